// File: rtl/usb_tx_bitstuffer.sv
// USB transmit serialiser: SYNC, LSB-first data with bit stuffing, then a 3-bit-time EOP request.
// Define USB_TX_CRC16_EN to build the optional CRC16 append for packets flagged with txCrc.
module usb_tx_bitstuffer #(
   parameter int unsigned GAP_BITS    = 2,
   parameter int unsigned STUFF_LIMIT = 6
) (
   input  logic       useClk,
   input  logic       rst,
   input  logic       bitStrobe,
   input  logic [7:0] txData,
   input  logic       txValid,
   input  logic       txLast,
   input  logic       txCrc,
   output logic       txReady,
   output logic       txBit,
   output logic       txOE,
   output logic       txEop,
   output logic       busy,
   output logic       txUnderrun
);

   localparam int unsigned       OnesW   = $clog2(STUFF_LIMIT + 1);
   localparam int unsigned       GapW    = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
   localparam logic [OnesW-1:0] OnesMax = OnesW'(STUFF_LIMIT);
   localparam logic [GapW-1:0]  GapInit = GapW'(GAP_BITS);

   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StData,
`ifdef USB_TX_CRC16_EN
      StCrc,
`endif
      StEop
   } state_e;

   state_e           state_q, state_d;
   logic             buf_full_q, buf_full_d;
   logic [7:0]       buf_data_q, buf_data_d;
   logic             buf_last_q, buf_last_d;
   logic [7:0]       shift_q, shift_d;
   logic             last_q, last_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [OnesW-1:0] ones_q, ones_d;
   logic [GapW-1:0]  gap_q, gap_d;
   logic             bit_q, bit_d;
   logic             oe_q, oe_d;
   logic             eop_q, eop_d;
   logic             underrun_q, underrun_d;
   logic             load;
   logic             start;
   logic             stuff_now;
`ifdef USB_TX_CRC16_EN
   logic             buf_crc_q, buf_crc_d;
   logic             crc_en_q, crc_en_d;
   logic             first_q, first_d;
   logic [15:0]      crc_q, crc_d;
`else
   logic             unused_crc;
   assign unused_crc = txCrc;
`endif

   assign start     = buf_full_q && (gap_q == '0);
   assign stuff_now = (ones_q == OnesMax);

   always_ff @(posedge useClk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         buf_full_q <= 1'b0;
         buf_data_q <= '0;
         buf_last_q <= 1'b0;
         shift_q    <= '0;
         last_q     <= 1'b0;
         bit_cnt_q  <= '0;
         ones_q     <= '0;
         gap_q      <= '0;
         bit_q      <= 1'b1;
         oe_q       <= 1'b0;
         eop_q      <= 1'b0;
         underrun_q <= 1'b0;
`ifdef USB_TX_CRC16_EN
         buf_crc_q  <= 1'b0;
         crc_en_q   <= 1'b0;
         first_q    <= 1'b0;
         crc_q      <= '1;
`endif
      end else begin
         state_q    <= state_d;
         buf_full_q <= buf_full_d;
         buf_data_q <= buf_data_d;
         buf_last_q <= buf_last_d;
         shift_q    <= shift_d;
         last_q     <= last_d;
         bit_cnt_q  <= bit_cnt_d;
         ones_q     <= ones_d;
         gap_q      <= gap_d;
         bit_q      <= bit_d;
         oe_q       <= oe_d;
         eop_q      <= eop_d;
         underrun_q <= underrun_d;
`ifdef USB_TX_CRC16_EN
         buf_crc_q  <= buf_crc_d;
         crc_en_q   <= crc_en_d;
         first_q    <= first_d;
         crc_q      <= crc_d;
`endif
      end
   end

   always_comb begin : next_state
      state_d    = state_q;
      buf_full_d = buf_full_q;
      buf_data_d = buf_data_q;
      buf_last_d = buf_last_q;
      shift_d    = shift_q;
      last_d     = last_q;
      bit_cnt_d  = bit_cnt_q;
      ones_d     = ones_q;
      gap_d      = gap_q;
      underrun_d = 1'b0;
      load       = 1'b0;
`ifdef USB_TX_CRC16_EN
      buf_crc_d  = buf_crc_q;
      crc_en_d   = crc_en_q;
      first_d    = first_q;
      crc_d      = crc_q;
`endif
      if (bitStrobe) begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  load      = 1'b1;
                  state_d   = StSync;
                  bit_cnt_d = 4'd1;
                  ones_d    = '0;
`ifdef USB_TX_CRC16_EN
                  crc_en_d  = buf_crc_q;
                  first_d   = 1'b1;
                  crc_d     = '1;
`endif
               end else if (gap_q != '0) begin
                  gap_d = gap_q - GapW'(1);
               end
            end
            StSync: begin
               bit_cnt_d = bit_cnt_q + 4'd1;
               ones_d    = '0;
               if (bit_cnt_q == 4'd7) begin
                  ones_d    = OnesW'(1);
                  bit_cnt_d = '0;
                  state_d   = StData;
               end
            end
            StData: begin
               if (stuff_now) begin
                  ones_d = '0;
               end else begin
                  ones_d    = shift_q[0] ? ones_q + OnesW'(1) : '0;
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 4'd1;
`ifdef USB_TX_CRC16_EN
                  // The PID byte is excluded from the CRC.
                  if (crc_en_q && !first_q) begin
                     crc_d = {1'b0, crc_q[15:1]} ^ ((shift_q[0] ^ crc_q[0]) ? 16'hA001 : 16'h0000);
                  end
`endif
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = '0;
                     if (last_q) begin
`ifdef USB_TX_CRC16_EN
                        state_d = crc_en_q ? StCrc : StEop;
`else
                        state_d = StEop;
`endif
                     end else if (buf_full_q) begin
                        load = 1'b1;
`ifdef USB_TX_CRC16_EN
                        first_d = 1'b0;
`endif
                     end else begin
                        // Underrun: abort straight to EOP, no trailing stuff bit.
                        underrun_d = 1'b1;
                        ones_d     = '0;
                        state_d    = StEop;
                     end
                  end
               end
            end
`ifdef USB_TX_CRC16_EN
            StCrc: begin
               if (stuff_now) begin
                  ones_d = '0;
               end else begin
                  ones_d = crc_q[0] ? '0 : ones_q + OnesW'(1);
                  crc_d  = {1'b1, crc_q[15:1]};
                  if (bit_cnt_q == 4'd15) begin
                     bit_cnt_d = '0;
                     state_d   = StEop;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
`endif
            StEop: begin
               if (bit_cnt_q == '0 && stuff_now) begin
                  ones_d = '0;
               end else if (bit_cnt_q == 4'd2) begin
                  state_d   = StIdle;
                  bit_cnt_d = '0;
                  ones_d    = '0;
                  gap_d     = GapInit;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
      if (load) begin
         shift_d    = buf_data_q;
         last_d     = buf_last_q;
         buf_full_d = 1'b0;
      end else if (txValid && !buf_full_q) begin
         buf_full_d = 1'b1;
         buf_data_d = txData;
         buf_last_d = txLast;
`ifdef USB_TX_CRC16_EN
         buf_crc_d  = txCrc;
`endif
      end
   end

   always_comb begin : line_next
      bit_d = bit_q;
      oe_d  = oe_q;
      eop_d = eop_q;
      if (bitStrobe) begin
         oe_d  = 1'b1;
         eop_d = 1'b0;
         unique case (state_q)
            StIdle: begin
               bit_d = ~start;
               oe_d  = start;
            end
            StSync: bit_d = (bit_cnt_q == 4'd7);
            StData: bit_d = ~stuff_now & shift_q[0];
`ifdef USB_TX_CRC16_EN
            StCrc:  bit_d = ~stuff_now & ~crc_q[0];
`endif
            StEop: begin
               if (bit_cnt_q == '0 && stuff_now) begin
                  bit_d = 1'b0;
               end else begin
                  bit_d = 1'b1;
                  eop_d = 1'b1;
               end
            end
            default: begin
               bit_d = 1'b1;
               oe_d  = 1'b0;
            end
         endcase
      end
   end

   assign txReady    = ~buf_full_q;
   assign txBit      = bit_q;
   assign txOE       = oe_q;
   assign txEop      = eop_q;
   assign txUnderrun = underrun_q;
   assign busy       = (state_q != StIdle) || (gap_q != '0);

endmodule

// File: tb/tb_usb_tx_bitstuffer.sv
// Scoreboard bench for usb_tx_bitstuffer: a packet-level model queues the expected line bits,
// and a monitor pops and compares them on every strobe that drives the line.
module tb_usb_tx_bitstuffer;

   localparam int unsigned GAP   = 2;
   localparam int unsigned STUFF = 6;

   logic       useClk = 1'b0;
   logic       rst;
   logic       bitStrobe;
   logic [7:0] txData;
   logic       txValid;
   logic       txLast;
   logic       txCrc;
   logic       txReady;
   logic       txBit;
   logic       txOE;
   logic       txEop;
   logic       busy;
   logic       txUnderrun;

   usb_tx_bitstuffer #(
      .GAP_BITS    (GAP),
      .STUFF_LIMIT (STUFF)
   ) dut (
      .useClk     (useClk),
      .rst        (rst),
      .bitStrobe  (bitStrobe),
      .txData     (txData),
      .txValid    (txValid),
      .txLast     (txLast),
      .txCrc      (txCrc),
      .txReady    (txReady),
      .txBit      (txBit),
      .txOE       (txOE),
      .txEop      (txEop),
      .busy       (busy),
      .txUnderrun (txUnderrun)
   );

   initial forever #5 useClk = ~useClk;

   int         errors = 0;
   int         checks = 0;
   logic [1:0] exp_q[$];    // {bit, eop} per line-driving strobe
   logic [7:0] pkt[$];
   int         popped = 0;
   int         underrun_pulses = 0;
   int         idle_run = 0;
   bit         gap_armed = 1'b0;
   bit         rst_seen = 1'b0;
   int         hold_cnt = 0;
   int         ph = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   // Bit-rate strobe every 4 clocks, with occasional long holds low.
   initial begin
      bitStrobe = 1'b0;
      forever begin
         @(negedge useClk);
         if (hold_cnt > 0) begin
            hold_cnt--;
            bitStrobe = 1'b0;
         end else if (ph == 3) begin
            bitStrobe = 1'b1;
            ph = 0;
            if ($urandom_range(0, 7) == 0) hold_cnt = 10;
         end else begin
            bitStrobe = 1'b0;
            ph++;
         end
      end
   end

   initial forever begin
      @(posedge rst);
      rst_seen = 1'b1;
   end

   // Monitor
   initial begin
      logic       s;
      logic [2:0] prev;
      logic [1:0] e;
      bit         prev_oe;
      prev    = 3'b100;
      prev_oe = 1'b0;
      forever begin
         @(posedge useClk);
         s = bitStrobe;
         #1;
         if (txUnderrun) underrun_pulses++;
         if (rst || rst_seen) begin
            rst_seen = 1'b0;
            prev     = {txBit, txOE, txEop};
            prev_oe  = 1'b0;
            idle_run = 0;
            continue;
         end
         if (!s) begin
            chk("hold_outputs", {29'd0, txBit, txOE, txEop}, {29'd0, prev});
         end else if (txOE) begin
            if (!prev_oe && gap_armed) begin
               chk("gap_strobes", idle_run, GAP);
               gap_armed = 1'b0;
            end
            chk("busy_in_packet", {31'd0, busy}, 1);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_bit: got bit=%b eop=%b want no drive", txBit, txEop);
            end else begin
               e = exp_q.pop_front();
               popped++;
               chk("line_bit_eop", {30'd0, txBit, txEop}, {30'd0, e});
            end
            idle_run = 0;
         end else begin
            idle_run++;
         end
         prev    = {txBit, txOE, txEop};
         prev_oe = txOE;
      end
   end

   // Reference model: SYNC, raw bits (+CRC), a stuffed 0 after every run of STUFF ones, 3x EOP.
   task automatic push_expected(input bit crc, input bit underrun);
      bit          s[$];
      int          ones;
      logic [15:0] c;
      for (int i = 0; i < 7; i++) exp_q.push_back(2'b00);
      exp_q.push_back(2'b10);
      ones = 1;
      foreach (pkt[i]) for (int j = 0; j < 8; j++) s.push_back(pkt[i][j]);
      if (crc) begin
         c = 16'hFFFF;
         for (int k = 8; k < s.size(); k++) begin
            c = (c >> 1) ^ ((s[k] ^ c[0]) ? 16'hA001 : 16'h0000);
         end
         for (int j = 0; j < 16; j++) s.push_back(~c[j]);
      end
      foreach (s[k]) begin
         exp_q.push_back({s[k], 1'b0});
         ones = s[k] ? ones + 1 : 0;
         if (ones == STUFF) begin
            if (!(underrun && k == s.size() - 1)) exp_q.push_back(2'b00);
            ones = 0;
         end
      end
      repeat (3) exp_q.push_back(2'b11);
   endtask

   task automatic send_byte(input logic [7:0] d, input bit last, input bit crc, input bit arm);
      int n = 0;
      @(negedge useClk);
      while (!txReady && n < 400) begin
         @(negedge useClk);
         n++;
      end
      if (!txReady) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got txReady=0 want 1 within 400 cycles");
         return;
      end
      if (arm) gap_armed = 1'b1;
      txData  = d;
      txLast  = last;
      txCrc   = crc;
      txValid = 1'b1;
      @(negedge useClk);
      txValid = 1'b0;
   endtask

   task automatic send_packet(input bit crc, input bit underrun, input bit arm_gap);
      push_expected(crc, underrun);
      foreach (pkt[i]) send_byte(pkt[i], (i == pkt.size() - 1) && !underrun, crc, arm_gap && i == 0);
   endtask

   task automatic wait_strobe();
      int n = 0;
      do begin
         @(posedge useClk);
         n++;
      end while (!bitStrobe && n < 100);
      #2;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 6000) begin
         @(posedge useClk);
         n++;
      end
      chk("drain_left", exp_q.size(), 0);
      repeat (GAP + 2) wait_strobe();
      chk("idle_busy", {31'd0, busy}, 0);
      chk("idle_oe", {31'd0, txOE}, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      rst     = 1'b1;
      txValid = 1'b0;
      txData  = '0;
      txLast  = 1'b0;
      txCrc   = 1'b0;
      repeat (3) @(posedge useClk);
      #1;
      chk("rst_ready", {31'd0, txReady}, 1);
      chk("rst_bit", {31'd0, txBit}, 1);
      chk("rst_oe", {31'd0, txOE}, 0);
      chk("rst_eop", {31'd0, txEop}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_underrun", {31'd0, txUnderrun}, 0);
      @(negedge useClk);
      rst = 1'b0;

      // ACK, then a queued packet that must wait out the inter-packet gap.
      pkt = '{8'hD2};
      send_packet(1'b0, 1'b0, 1'b0);
      pkt = '{8'h4B};
      send_packet(1'b0, 1'b0, 1'b1);
      wait_drain();
      chk("gap_consumed", {31'd0, gap_armed}, 0);

      // All ones: one stuffed bit inside the byte.
      pkt = '{8'hFF};
      send_packet(1'b0, 1'b0, 1'b0);
      wait_drain();
      pkt = '{8'h3F, 8'hFF};
      send_packet(1'b0, 1'b0, 1'b0);
      wait_drain();

      // Underrun: second byte arrives only after the abort.
      pkt = '{8'h5A};
      send_packet(1'b0, 1'b1, 1'b0);
      wait_drain();
      chk("underrun_pulse", underrun_pulses, 1);
      pkt = '{8'h00};
      send_packet(1'b0, 1'b0, 1'b0);
      wait_drain();

      // Asynchronous reset mid-DATA.
      base = popped;
      pkt  = '{8'h00};
      send_packet(1'b0, 1'b0, 1'b0);
      n = 0;
      while (popped < base + 12 && n < 2000) begin
         @(posedge useClk);
         n++;
      end
      chk("reached_data", {31'd0, popped >= base + 12}, 1);
      @(posedge useClk);
      #3;
      rst = 1'b1;
      #1;
      chk("midrst_oe", {31'd0, txOE}, 0);
      chk("midrst_eop", {31'd0, txEop}, 0);
      chk("midrst_ready", {31'd0, txReady}, 1);
      chk("midrst_busy", {31'd0, busy}, 0);
      exp_q.delete();
      #1;
      rst = 1'b0;
      pkt = '{8'hA5, 8'h0F};
      send_packet(1'b0, 1'b0, 1'b0);
      wait_drain();

      // Random back-to-back packets biased towards long runs of ones.
      for (int p = 0; p < 15; p++) begin
         int len;
         logic [7:0] b;
         pkt.delete();
         len = $urandom_range(1, 3);
         for (int i = 0; i < len; i++) begin
            case ($urandom_range(0, 3))
               0: b = 8'hFF;
               1: b = 8'hFE | 8'($urandom_range(0, 1));
               default: b = 8'($urandom);
            endcase
            pkt.push_back(b);
         end
         send_packet(1'b0, 1'b0, p > 0);
      end
      wait_drain();

`ifdef USB_TX_CRC16_EN
      pkt = '{8'hC3};
      send_packet(1'b1, 1'b0, 1'b0);
      wait_drain();
      pkt = '{8'hC3, 8'h00, 8'h01, 8'h02, 8'h03};
      send_packet(1'b1, 1'b0, 1'b0);
      wait_drain();
`endif

      chk("underrun_total", underrun_pulses, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/usb_tx_bitstuffer.md
Name: usb_tx_bitstuffer

Overview:
- Upstream neighbour of the NRZI line encoder in the USB transmit path.
- Accepts packet bytes over a valid/ready handshake and serialises them LSB-first at the bit-rate strobe.
- Prepends SYNC, applies USB bit stuffing, then requests a 3-bit-time EOP.
- Drives the encoder's data bit, output-enable and EOP-request inputs (1 = hold line level, 0 = toggle).

Parameters:
GAP_BITS, 2, minimum bit-strobe count spent in IDLE after an EOP before the next SYNC may start (0 allowed)
STUFF_LIMIT, 6, consecutive emitted ones after which a stuffed 0 is inserted

Ports:
useClk  in  1  system clock
rst  in  1  asynchronous active-high reset
bitStrobe  in  1  one-cycle bit-rate enable; all bit-level state advances only when high
txData  in  8  packet byte
txValid  in  1  txData valid
txLast  in  1  byte is final byte of packet; qualified by txValid
txCrc  in  1  append CRC16; sampled with first byte (used only with the optional feature)
txReady  out  1  byte buffer empty; byte accepted when txValid && txReady
txBit  out  1  data bit to encoder (1 = no transition)
txOE  out  1  line drive enable
txEop  out  1  EOP request to encoder
busy  out  1  packet in progress (SYNC..EOP or gap)
txUnderrun  out  1  one-cycle pulse: abort caused by buffer empty mid-packet

Behaviour:
- Reset (async, any state): state IDLE; txReady=1, txBit=1, txOE=0, txEop=0, busy=0, txUnderrun=0; buffer, ones counter and gap counter cleared; EOP aborted.
- Buffer: one-entry holding register plus 8-bit shift register. txReady = !bufFull, independent of bitStrobe.
- Same-cycle accept and load: the buffer is full for that cycle only; txReady is deasserted next cycle, then reasserted after the load.
- Registered outputs update only on bitStrobe cycles; each strobe presents exactly one bit.
- IDLE: txOE=0.
  - On a strobe with bufFull and gap counter expired: load shift register from buffer; capture last flag and CRC flag.
  - Emit first SYNC bit (txBit=0, txOE=1), go to SYNC.
- SYNC: remaining 7 strobes emit 0,0,0,0,0,0,1 (SYNC = 0x80 LSB-first). The final 1 sets the ones counter to 1. Then go to DATA.
- Ones counter:
  - Increments on each emitted 1; clears on each emitted 0.
  - When it reaches STUFF_LIMIT, the next strobe emits a stuffed 0 (STUFF state) without consuming a data bit, then processing resumes.
  - Stuffing also applies after the final data/CRC bit, before EOP.
- DATA: each strobe emits shift[0] and shifts right; the bit index counts 0..7. On the strobe emitting bit 7:
  - last flag set: after any pending stuff, go to EOP (or CRC with the feature);
  - else bufFull: load next byte into the shift register and clear the buffer;
  - else: underrun. Pulse txUnderrun for one clock, go to EOP without stuffing.
- EOP: 3 strobes with txEop=1, txOE=1, txBit=1. Then go to IDLE with txOE=0, txEop=0; gap counter loads GAP_BITS.
- busy is high from the SYNC load until the gap counter reaches 0.
- txValid while busy: accepted into the buffer when empty; no effect on the current packet beyond the load rules above.

Optional Feature:
USB_TX_CRC16_EN
- Defined:
  - If the captured CRC flag is set, every byte after the first (PID) feeds CRC16 (poly 0x8005, init 0xFFFF, LSB-first).
  - After the last byte, CRC state emits 16 bits of the inverted remainder LSB-first, subject to stuffing, then EOP.
  - CRC resets at SYNC load.
- Undefined: txCrc ignored; no CRC logic or state synthesised.

Test Plan:
- ACK byte 0xD2, txLast=1 -> strobes give txBit 0,0,0,0,0,0,0,1, 0,1,0,0,1,0,1,1 (txOE=1), then 3 strobes txEop=1, then txOE=0; GAP_BITS strobes pass before a queued packet's SYNC.
- Byte 0xFF last -> after SYNC: 1,1,1,1,1,0(stuff),1,1,1, then EOP; exactly 17 strobes before txEop.
- Two bytes 0x5A then 0x00 held off past bit 7 -> txUnderrun pulses once, EOP follows immediately, no second byte bits.
- rst pulsed mid-DATA, between clock edges -> txOE=0, txEop=0, txReady=1 before the next edge; next packet restarts with a full SYNC.
- bitStrobe held low 10 cycles mid-byte -> txBit/txOE/txEop unchanged, no bit lost or duplicated.
- (USB_TX_CRC16_EN) byte 0xC3, txCrc=1, txLast=1 -> after PID bits, 16 zeros with stuffing irrelevant, then EOP.
